// File: rtl/pmod8led2_pkg.sv
// pmod8led2_pkg: shared definitions for the bicolour 8-LED pmod driver.
//   - state_e   : colour-phase FSM encoding
//   - GAMMA     : 16-entry brightness curve, used when PMOD8LED2_GAMMA_EN is defined
//   - *_DEF     : default timing parameters (25 MHz clock, ~1 kHz frame rate)
//   - SLOT_W    : width of the PWM slot index
//   - cyc_width : width of the per-slot / dead-time cycle counter
package pmod8led2_pkg;

  localparam int SLOT_CYC_DEF  = 781;
  localparam int PWM_STEPS_DEF = 16;
  localparam int DEAD_CYC_DEF  = 8;
  localparam int LED_N         = 8;
  localparam int SLOT_W        = $clog2(PWM_STEPS_DEF);

  typedef enum logic [1:0] {
    ST_G   = 2'd0,
    ST_DGR = 2'd1,
    ST_R   = 2'd2,
    ST_DRG = 2'd3
  } state_e;

  localparam logic [3:0] GAMMA [16] = '{
    4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15
  };

  // The cycle counter is shared by the PWM slots and the dead time, so it
  // must hold the larger of the two terminal counts.
  function automatic int cyc_width(input int slot_cyc, input int dead_cyc);
    int m;
    m = (slot_cyc > dead_cyc) ? slot_cyc : dead_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pmod8led2_pwm_timer.sv
// pmod8led2_pwm_timer: cycle and slot counters for one colour phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   dead       : 1 while the FSM is in a dead-time state
//   slot       : current PWM slot within the colour phase
//   slot_end   : last clock of the current slot (colour phases only)
//   phase_end  : last clock of the current phase; both counters clear after it
module pmod8led2_pwm_timer
  import pmod8led2_pkg::*;
#(
  parameter int SLOT_CYC  = SLOT_CYC_DEF,
  parameter int PWM_STEPS = PWM_STEPS_DEF,
  parameter int DEAD_CYC  = DEAD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dead,
  output logic [SLOT_W-1:0] slot,
  output logic              slot_end,
  output logic              phase_end
);

  localparam int CNT_W = cyc_width(SLOT_CYC, DEAD_CYC);
  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [SLOT_W-1:0] STEP_LAST = SLOT_W'(PWM_STEPS - 1);

  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_end  = ~dead & (cyc_q == SLOT_LAST);
    phase_end = dead ? (cyc_q == DEAD_LAST) : (slot_end & (slot_q == STEP_LAST));
    cyc_d     = cyc_q + 1'b1;
    slot_d    = slot_q;
    if (phase_end) begin
      cyc_d  = '0;
      slot_d = '0;
    end else if (slot_end) begin
      cyc_d  = '0;
      slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      slot_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/pmod8led2_drv.sv
// pmod8led2_drv: output stage for the bicolour 8-LED pmod.
// Frames (green, red, brightness) arrive over valid/ready into a one-deep
// pending buffer and are copied to the shadow registers on the last clock of
// ST_DRG, so a frame is never changed part-way through. Green and red are
// time-multiplexed with all-off dead time between them and PWM-dimmed.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : frame offered
//   in_ready    : pending buffer empty
//   in_g, in_r  : green / red patterns, bit i drives LED i
//   in_bright   : 0 = off .. 15 = 15/16 duty
//   pmodledg/r  : registered pins, pin i = LED i
//   frame_start : one-clock pulse on the first clock of each ST_G
// Handshake: a frame transfers on any rising clk edge where in_valid and
// in_ready are both high; in_ready depends only on the pending flag.
// Build option: define PMOD8LED2_GAMMA_EN to map brightness through GAMMA.
module pmod8led2_drv
  import pmod8led2_pkg::*;
#(
  parameter int SLOT_CYC  = SLOT_CYC_DEF,
  parameter int PWM_STEPS = PWM_STEPS_DEF,
  parameter int DEAD_CYC  = DEAD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_g,
  input  logic [7:0] in_r,
  input  logic [3:0] in_bright,
  output logic [0:7] pmodledg,
  output logic [0:7] pmodledr,
  output logic       frame_start
);

  state_e state_q, state_d;

  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_g_q, pend_g_d, pend_r_q, pend_r_d;
  logic [3:0] pend_bright_q, pend_bright_d;
  logic [7:0] sh_g_q, sh_g_d, sh_r_q, sh_r_d;
  logic [3:0] sh_bright_q, sh_bright_d;
  logic [0:7] led_g_q, led_g_d, led_r_q, led_r_d;
  logic       frame_start_q, frame_start_d;

  logic              dead, accept, boundary, lit;
  logic [SLOT_W-1:0] slot;
  logic              slot_end, phase_end;
  logic [3:0]        duty;

  // slot_end is exported by the timer for observability; nothing here needs it.
  logic unused_slot_end;
  assign unused_slot_end = slot_end;

  assign dead = (state_q == ST_DGR) || (state_q == ST_DRG);

  pmod8led2_pwm_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .PWM_STEPS (PWM_STEPS),
    .DEAD_CYC  (DEAD_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .dead      (dead),
    .slot      (slot),
    .slot_end  (slot_end),
    .phase_end (phase_end)
  );

`ifdef PMOD8LED2_GAMMA_EN
  assign duty = GAMMA[sh_bright_q];
`else
  assign duty = sh_bright_q;
`endif

  assign in_ready = ~pend_vld_q;
  assign accept   = in_valid & ~pend_vld_q;
  assign boundary = (state_q == ST_DRG) & phase_end;
  assign lit      = (slot < duty);

  always_comb begin
    state_d = state_q;
    if (phase_end) begin
      case (state_q)
        ST_G:    state_d = ST_DGR;
        ST_DGR:  state_d = ST_R;
        ST_R:    state_d = ST_DRG;
        default: state_d = ST_G;
      endcase
    end
  end

  // accept needs pend_vld_q = 0 and the boundary copy needs pend_vld_q = 1,
  // so the two never happen on the same clock and a held frame is never
  // overwritten.
  always_comb begin
    pend_vld_d    = pend_vld_q;
    pend_g_d      = pend_g_q;
    pend_r_d      = pend_r_q;
    pend_bright_d = pend_bright_q;
    sh_g_d        = sh_g_q;
    sh_r_d        = sh_r_q;
    sh_bright_d   = sh_bright_q;
    if (accept) begin
      pend_vld_d    = 1'b1;
      pend_g_d      = in_g;
      pend_r_d      = in_r;
      pend_bright_d = in_bright;
    end else if (boundary && pend_vld_q) begin
      pend_vld_d  = 1'b0;
      sh_g_d      = pend_g_q;
      sh_r_d      = pend_r_q;
      sh_bright_d = pend_bright_q;
    end
  end

  always_comb begin
    led_g_d       = '0;
    led_r_d       = '0;
    frame_start_d = boundary;
    for (int i = 0; i < LED_N; i++) begin
      led_g_d[i] = (state_q == ST_G) & sh_g_q[i] & lit;
      led_r_d[i] = (state_q == ST_R) & sh_r_q[i] & lit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_G;
      pend_vld_q    <= 1'b0;
      pend_g_q      <= '0;
      pend_r_q      <= '0;
      pend_bright_q <= '0;
      sh_g_q        <= '0;
      sh_r_q        <= '0;
      sh_bright_q   <= '0;
      led_g_q       <= '0;
      led_r_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_g_q      <= pend_g_d;
      pend_r_q      <= pend_r_d;
      pend_bright_q <= pend_bright_d;
      sh_g_q        <= sh_g_d;
      sh_r_q        <= sh_r_d;
      sh_bright_q   <= sh_bright_d;
      led_g_q       <= led_g_d;
      led_r_q       <= led_r_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pmodledg    = led_g_q;
  assign pmodledr    = led_r_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pmod8led2_drv.sv
// tb_pmod8led2_drv: directed bench for pmod8led2_drv with SLOT_CYC=2,
// DEAD_CYC=2 (68-clock frames). Each frame, between two frame_start pulses,
// the per-pin on-clock counts are measured and compared with the counts
// expected from the frame the bench believes is displayed.
module tb_pmod8led2_drv;

  localparam int TB_SLOT_CYC = 2;
  localparam int TB_DEAD_CYC = 2;
  localparam int W = 96;

`ifdef PMOD8LED2_GAMMA_EN
  localparam logic [3:0] TB_GAMMA [16] = '{
    4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15
  };
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_g;
  logic [7:0] in_r;
  logic [3:0] in_bright;
  logic [0:7] pmodledg;
  logic [0:7] pmodledr;
  logic       frame_start;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  pmod8led2_drv #(
    .SLOT_CYC  (TB_SLOT_CYC),
    .PWM_STEPS (16),
    .DEAD_CYC  (TB_DEAD_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_g        (in_g),
    .in_r        (in_r),
    .in_bright   (in_bright),
    .pmodledg    (pmodledg),
    .pmodledr    (pmodledr),
    .frame_start (frame_start)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected on-clocks per pin for one frame: 6 bits per pin, green pins
  // 0..7 in the low half, red pins 0..7 in the high half.
  function automatic logic [W-1:0] exp_counts(input logic [7:0] g, input logic [7:0] r,
                                              input logic [3:0] b);
    logic [W-1:0] v;
    int d;
`ifdef PMOD8LED2_GAMMA_EN
    d = int'(TB_GAMMA[b]);
`else
    d = int'(b);
`endif
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) v[i*6 +: 6] = 6'(d * TB_SLOT_CYC);
      if (r[i]) v[48 + i*6 +: 6] = 6'(d * TB_SLOT_CYC);
    end
    return v;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0]   mdl_sh_g, mdl_sh_r, mdl_pend_g, mdl_pend_r, last_g, last_r;
  logic [3:0]   mdl_sh_b, mdl_pend_b, last_b;
  logic         mdl_pend_vld, last_xfer, win_act;
  int           g_cnt [8];
  int           r_cnt [8];
  int           ovl;
  logic [W-1:0] meas;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_sh_g = '0; mdl_sh_r = '0; mdl_sh_b = '0;
      mdl_pend_vld = 1'b0; last_xfer = 1'b0; win_act = 1'b0;
      exp_q.delete();
    end else begin
      if (frame_start) begin
        if (win_act) begin
          meas = '0;
          for (int i = 0; i < 8; i++) begin
            meas[i*6 +: 6]      = 6'(g_cnt[i]);
            meas[48 + i*6 +: 6] = 6'(r_cnt[i]);
          end
          check("sb_depth", W'(exp_q.size()), W'(1));
          if (exp_q.size() > 0) check("frame_counts", meas, exp_q.pop_front());
          check("overlap", W'(ovl), W'(0));
        end
        if (mdl_pend_vld) begin
          mdl_sh_g = mdl_pend_g; mdl_sh_r = mdl_pend_r; mdl_sh_b = mdl_pend_b;
          mdl_pend_vld = 1'b0;
        end
        exp_q.push_back(exp_counts(mdl_sh_g, mdl_sh_r, mdl_sh_b));
        win_act = 1'b1;
        ovl = 0;
        for (int i = 0; i < 8; i++) begin
          g_cnt[i] = 0;
          r_cnt[i] = 0;
        end
      end
      // A transfer seen at the previous negedge happened at the edge just
      // passed, after any boundary copy on that edge.
      if (last_xfer) begin
        mdl_pend_g = last_g; mdl_pend_r = last_r; mdl_pend_b = last_b;
        mdl_pend_vld = 1'b1;
      end
      if (win_act) begin
        for (int i = 0; i < 8; i++) begin
          g_cnt[i] += int'(pmodledg[i]);
          r_cnt[i] += int'(pmodledr[i]);
          if (pmodledg[i] && pmodledr[i]) ovl++;
        end
      end
      last_xfer = in_valid && in_ready;
      last_g = in_g; last_r = in_r; last_b = in_bright;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] g, input logic [7:0] r, input logic [3:0] b);
    bit ok;
    @(posedge clk); #2;
    in_valid = 1'b1; in_g = g; in_r = r; in_bright = b;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("send_accept", W'(ok), W'(1));
  endtask

  task automatic wait_frame_start();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_start_seen", W'(ok), W'(1));
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] rb;
  logic [0:7] exp_pins;
  bit         found;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_g = '0; in_r = '0; in_bright = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ledg", W'(pmodledg), W'(0));
    check("rst_ledr", W'(pmodledr), W'(0));
    check("rst_frame_start", W'(frame_start), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Full green at 15/16
    send_frame(8'hFF, 8'h00, 4'd15);
    @(negedge clk);
    check("ready_low_after_accept", W'(in_ready), W'(0));
    repeat (3) wait_frame_start();

    // Amber on LEDs 0..3
    send_frame(8'h0F, 8'h0F, 4'd8);
    repeat (3) wait_frame_start();

    // Backpressure and boundary collision
    wait_frame_start();
    send_frame(8'h55, 8'hAA, 4'd4);
    in_valid = 1'b1; in_g = 8'h3C; in_r = 8'hC3; in_bright = 4'd12;
    @(negedge clk);
    check("bp_ready_low", W'(in_ready), W'(0));
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("bp_ready_rises", W'(found), W'(1));
    check("collision_at_boundary", W'(frame_start), W'(1));
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_ready_after_accept", W'(in_ready), W'(0));
    repeat (2) wait_frame_start();

    // Mid-frame reset during ST_R with a frame pending
    wait_frame_start();
    send_frame(8'hF0, 8'h0F, 4'd15);
    repeat (38) @(negedge clk);
    rb = 8'hC3;
    for (int i = 0; i < 8; i++) exp_pins[i] = rb[i];
    check("pre_reset_ledr", W'(pmodledr), W'(exp_pins));
    check("pre_reset_ledg", W'(pmodledg), W'(0));
    check("pre_reset_ready", W'(in_ready), W'(0));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ledr", W'(pmodledr), W'(0));
    check("async_rst_ledg", W'(pmodledg), W'(0));
    check("async_rst_ready", W'(in_ready), W'(1));
    check("async_rst_frame_start", W'(frame_start), W'(0));
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    // Pending frame was discarded: frames stay dark
    repeat (2) wait_frame_start();

    // Normal operation resumes
    send_frame(8'h81, 8'h18, 4'd15);
    repeat (3) wait_frame_start();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmod8led2_drv.md
Name: pmod8led2_drv

Overview:
- Output stage for the bicolour 8-LED pmod. Sits directly downstream of the counter/pattern generators that produce green and red LED vectors.
- Accepts frames of green pattern, red pattern and brightness over a valid/ready handshake.
- Drives the pins with PWM brightness and green/red time-multiplexing separated by dead time. An LED set in both vectors therefore shows amber, and green and red are never driven in the same cycle.
- New frames are applied only at frame boundaries, so the display never glitches.

Parameters:
- SLOT_CYC, 781: clocks per PWM slot. 25 MHz / (2 phases x 16 slots x 781) gives about a 1 kHz frame rate.
- PWM_STEPS, 16: PWM slots per colour phase. Must be 16 (4-bit brightness).
- DEAD_CYC, 8: all-off clocks between phases. Must be >= 1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: a frame is offered.
- in_ready, output, 1: the pending buffer is empty and a frame can be accepted.
- in_g, input, 8: green pattern, bit i drives LED i.
- in_r, input, 8: red pattern, bit i drives LED i.
- in_bright, input, 4: brightness. 0 = off, 15 = 15/16 duty.
- pmodledg, output, [0:7]: green pins, registered.
- pmodledr, output, [0:7]: red pins, registered.
- frame_start, output, 1: one-clock pulse on the first clock of each ST_G.

Behaviour:
- Clock is clk. Reset is asynchronous active-low on rst_n. All state is reset asynchronously.
- Reset values:
  - pmodledg = 0, pmodledr = 0, frame_start = 0.
  - Shadow registers (g, r, bright) = 0.
  - Pending buffer empty, so in_ready = 1.
  - FSM = ST_G, slot = 0, cycle counter = 0.
- Handshake:
  - in_ready = ~pend_vld, combinational from the register.
  - Transfer occurs on a clock where in_valid & in_ready. The frame is captured into the pending buffer and pend_vld is set.
  - Data presented without in_ready is ignored. No overwrite of the pending frame.
- FSM states: ST_G, ST_DGR, ST_R, ST_DRG.
  - ST_G: lasts PWM_STEPS x SLOT_CYC clocks, then goes to ST_DGR.
  - ST_DGR: lasts DEAD_CYC clocks, then goes to ST_R.
  - ST_R: lasts PWM_STEPS x SLOT_CYC clocks, then goes to ST_DRG.
  - ST_DRG: lasts DEAD_CYC clocks, then goes to ST_G.
  - The cycle counter wraps at SLOT_CYC-1, which increments slot. Slot wraps at PWM_STEPS-1, which ends the phase. Both counters clear on every state change.
- Frame boundary (last clock of ST_DRG): if pend_vld, copy pending into the shadow registers and clear pend_vld. in_ready rises on the next clock.
  - If in_valid is high on the boundary clock while pend_vld = 1, it is not accepted.
  - If pend_vld = 0 at the boundary, the shadow registers hold their values and the previous frame repeats.
- Output registers, one clock after the state/slot that produced them:
  - In ST_G: pmodledg[i] = sh_g[i] & (slot < duty); pmodledr = 0.
  - In ST_R: pmodledr[i] = sh_r[i] & (slot < duty); pmodledg = 0.
  - In ST_DGR and ST_DRG: both outputs = 0.
  - Invariant: (pmodledg & pmodledr) == 0 on every cycle.
  - duty = sh_bright (4-bit, unsigned compare against a 4-bit slot).
  - Bit i of in_g maps to pin pmodledg[i]; no reversal.
- Frame length = 2 x (PWM_STEPS x SLOT_CYC + DEAD_CYC) clocks. Apply-latency from acceptance is at most one frame plus one clock.
- An rst_n assertion mid-frame forces outputs to 0 immediately (asynchronously) and discards the pending frame.

Optional Feature:
- Macro: PMOD8LED2_GAMMA_EN.
- Defined: duty = GAMMA[sh_bright], with GAMMA = {0,1,1,1,2,2,3,3,4,5,6,7,9,11,13,15}. The ROM is indexed by a 4-bit value with a 4-bit result.
- Undefined: duty = sh_bright (linear). There is no ROM and no extra logic.

Decomposition:
- Package pmod8led2_pkg holds:
  - the state encoding (ST_G = 2'd0, ST_DGR = 2'd1, ST_R = 2'd2, ST_DRG = 2'd3);
  - the 16-entry GAMMA constant;
  - localparam widths derived from SLOT_CYC and PWM_STEPS via $clog2.
- One sub-module, pmod8led2_pwm_timer: owns the cycle/slot counters and produces slot, phase_end and slot_end.
- The FSM, handshake and output logic stay in the top module.

Test Plan (bench uses SLOT_CYC=2, DEAD_CYC=2 for speed; frame = 68 clocks):
- Reset check: hold rst_n = 0 -> outputs 0, in_ready = 1. Release, accept g=8'hFF, r=0, bright=15 -> from the second frame on, pmodledg=FF for 30 of the 32 ST_G clocks; pmodledr stays 0.
- Amber: g=r=8'h0F, bright=8 -> each of pmodledg[0:3] and pmodledr[0:3] is high 16 clocks per frame and never in the same clock; pins 4-7 are always 0.
- Backpressure: offer frame A, then frame B while pend_vld=1 -> in_ready=0 and B is not captured. After the boundary, in_ready=1; B is accepted and shows in the following frame.
- Boundary collision: in_valid high on the last ST_DRG clock with pend_vld=1 -> no acceptance that clock; acceptance occurs the next clock.
- Mid-frame reset: assert rst_n during ST_R -> pmodledr=0 within the same clock with no clk edge; pending frame lost; in_ready=1.
- Gamma (macro defined): bright=4 -> 2 slots on (4 clocks per phase). Macro undefined -> 4 slots (8 clocks).
